// File: rtl/cmp_pkg.sv
// cmp_pkg: compare-op encodings, operand width, arbiter output-stage states and the shared comparator.
package cmp_pkg;
  localparam int CMP_W = 32;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;
  typedef enum logic {EMPTY, FULL} state_t;
  // Returns {err, taken}; unused encodings flag err and never report taken.
  function automatic logic [1:0] cmp_eval(input logic [2:0] op, input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
    logic eq, lt, ltu;
    eq  = a == b;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    case (op)
      CMP_EQ:  return {1'b0, eq};
      CMP_NE:  return {1'b0, !eq};
      CMP_LT:  return {1'b0, lt};
      CMP_LTU: return {1'b0, ltu};
      CMP_GE:  return {1'b0, !lt};
      CMP_GEU: return {1'b0, !ltu};
      default: return 2'b10;
    endcase
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after last, one-hot grant gated by en.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  logic found;
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[(int'(last) + i) % N_REQ]) begin
        found = 1'b1;
        idx   = ID_W'((int'(last) + i) % N_REQ);
      end
    end
    any   = en && found;
    grant = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one branch comparator shared round-robin by N_REQ requesters, 1-deep registered result.
// Define CMP_ARB_STATS_EN to add the saturating stat_taken_cnt output.
module cmp_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_ctrl,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_taken,
  output logic               rsp_err
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [31:0]        stat_taken_cnt
`endif
);
  import cmp_pkg::*;
  state_t state, state_nx;
  logic [ID_W-1:0] last_grant, gidx;
  logic can_accept, xfer;
  logic [CMP_W-1:0] sel_a, sel_b;
  logic [2:0] sel_ctrl;
  logic [1:0] res;
  assign can_accept = state == EMPTY || rsp_ready;
  // Gating with rst_n keeps req_ready low while reset is held.
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .en    (can_accept && rst_n),
    .grant (req_ready),
    .idx   (gidx),
    .any   (xfer)
  );
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gidx) begin
        sel_a    = req_a[CMP_W*i +: CMP_W];
        sel_b    = req_b[CMP_W*i +: CMP_W];
        sel_ctrl = req_ctrl[3*i +: 3];
      end
    end
  end
  assign res = cmp_eval(sel_ctrl, sel_a, sel_b);
  always_comb state_nx = xfer ? FULL : (rsp_ready ? EMPTY : state);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_REQ - 1);
      rsp_id     <= '0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (xfer) begin
      last_grant <= gidx;
      rsp_id     <= gidx;
      {rsp_err, rsp_taken} <= res;
    end
  end
  assign rsp_valid = state == FULL;
`ifdef CMP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_taken_cnt <= '0;
    else if (rsp_valid && rsp_ready && rsp_taken && stat_taken_cnt != '1) stat_taken_cnt <= stat_taken_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed stimulus with a result scoreboard drained by an independent monitor.
module tb_cmp_share_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_valid = 2'b11, req_ready;
  logic [63:0] req_a = '0, req_b = '0;
  logic [5:0] req_ctrl = '0;
  logic rsp_valid, rsp_taken, rsp_err;
  logic [0:0] rsp_id;
`ifdef CMP_ARB_STATS_EN
  logic [31:0] stat_taken_cnt;
`endif
  int checks = 0, failures = 0, exp_taken_cnt = 0;
  logic exp_tk [2], exp_er [2];
  typedef struct {logic id; logic tk; logic er;} exp_t;
  exp_t q[$];

  cmp_share_arbiter #(.N_REQ(2), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_taken(rsp_taken), .rsp_err(rsp_err)
`ifdef CMP_ARB_STATS_EN
    , .stat_taken_cnt(stat_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic tk, input logic er);
    req_ctrl[3*i +: 3] = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    exp_tk[i] = tk;
    exp_er[i] = er;
  endtask

  task automatic cyc(input logic [1:0] v, input logic rr, input logic [1:0] exp_rdy);
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy[0]) q.push_back('{1'b0, exp_tk[0], exp_er[0]});
    if (exp_rdy[1]) q.push_back('{1'b1, exp_tk[1], exp_er[1]});
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_taken", 32'(rsp_taken), 32'(e.tk));
        chk("rsp_err", 32'(rsp_err), 32'(e.er));
        if (e.tk) exp_taken_cnt++;
      end
    end
  end

  initial begin
    // Reset held with both requesters asking
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Signed vs unsigned compare of -1 against 1
    set_op(0, 3'b011, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    set_op(1, 3'b001, 32'd0, 32'd0, 1'b1, 1'b0);
    cyc(2'b11, 1'b1, 2'b01);
    set_op(0, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 2'b01);
    // Continuous contention alternates
    set_op(0, 3'b001, 32'd7, 32'd7, 1'b1, 1'b0);
    set_op(1, 3'b101, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 2'b10);
    cyc(2'b11, 1'b1, 2'b01);
    cyc(2'b11, 1'b1, 2'b10);
    cyc(2'b11, 1'b1, 2'b01);
    // Back-pressure: held result is id0 taken=1 err=0
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 1'b0, 2'b00);
      chk("hold_rsp", {28'd0, rsp_valid, rsp_id, rsp_taken, rsp_err}, 32'b1010);
    end
    cyc(2'b11, 1'b1, 2'b10);
    set_op(1, 3'b110, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 2'b10);
    cyc(2'b00, 1'b1, 2'b00);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    // Invalid encodings still transfer; pointer held across idle
    set_op(0, 3'b111, 32'd5, 32'd5, 1'b0, 1'b1);
    set_op(1, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1);
    cyc(2'b11, 1'b1, 2'b01);
    cyc(2'b11, 1'b1, 2'b10);
    set_op(0, 3'b001, 32'd5, 32'd5, 1'b1, 1'b0);
    cyc(2'b01, 1'b1, 2'b01);
    set_op(1, 3'b010, 32'd5, 32'd6, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 2'b10);
    cyc(2'b00, 1'b1, 2'b00);
    // Async reset while FULL with pointer at 1
    cyc(2'b10, 1'b0, 2'b10);
    req_valid = 2'b11;
    #2;
    chk("full_before_reset", 32'(rsp_valid), 32'd1);
`ifdef CMP_ARB_STATS_EN
    chk("stat_taken_cnt", stat_taken_cnt, 32'(exp_taken_cnt));
`endif
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    q.delete();
`ifdef CMP_ARB_STATS_EN
    chk("stat_after_reset", stat_taken_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(2'b11, 1'b1, 2'b01);
    cyc(2'b00, 1'b1, 2'b00);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
